axi_riscv_lrsc_res_table: RTL

AXI_RISCV_LRSC_RES_TABLE -- requirements
Module: axi_riscv_lrsc_res_table

---
 rtl/axi_riscv_lrsc_res_table_if.sv | 37 +++
 rtl/axi_riscv_lrsc_res_table.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/axi_riscv_lrsc_res_table_if.sv
// LR/SC reservation table bus: LR observe, SC check/response, write snoop.
// The table side takes the slave modport.
interface axi_riscv_lrsc_res_table_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 0,
    parameter int unsigned AXI_ID_WIDTH   = 0
);
    logic                      lr_valid_i;
    logic [AXI_ID_WIDTH-1:0]   lr_id_i;
    logic [AXI_ADDR_WIDTH-1:0] lr_addr_i;
    logic                      sc_valid_i;
    logic                      sc_ready_o;
    logic [AXI_ID_WIDTH-1:0]   sc_id_i;
    logic [AXI_ADDR_WIDTH-1:0] sc_addr_i;
    logic                      sc_rsp_valid_o;
    logic                      sc_rsp_ready_i;
    logic                      sc_rsp_ok_o;
    logic                      wr_valid_i;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_i;

    modport slave (
        input  lr_valid_i, lr_id_i, lr_addr_i,
        input  sc_valid_i, sc_id_i, sc_addr_i,
        output sc_ready_o,
        output sc_rsp_valid_o, sc_rsp_ok_o,
        input  sc_rsp_ready_i,
        input  wr_valid_i, wr_addr_i
    );

    modport master (
        output lr_valid_i, lr_id_i, lr_addr_i,
        output sc_valid_i, sc_id_i, sc_addr_i,
        input  sc_ready_o,
        input  sc_rsp_valid_o, sc_rsp_ok_o,
        output sc_rsp_ready_i,
        output wr_valid_i, wr_addr_i
    );
endinterface

// File: rtl/axi_riscv_lrsc_res_table.sv
// Reservation table for AXI exclusive (LR/SC) accesses with write snooping.
// One slot per id; full table evicts round-robin.
module axi_riscv_lrsc_res_table #(
    parameter longint unsigned ADDR_BEGIN     = 0,
    parameter longint unsigned ADDR_END       = 0,
    parameter int unsigned     AXI_ADDR_WIDTH = 0,
    parameter int unsigned     AXI_ID_WIDTH   = 0,
    parameter int unsigned     NUM_RES        = 4,
    parameter int unsigned     GRAN_BYTES     = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    axi_riscv_lrsc_res_table_if.slave        bus,
    output logic [$clog2(NUM_RES+1)-1:0]     occupancy_o
);
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned IW = AXI_ID_WIDTH;
    localparam int unsigned GW = $clog2(GRAN_BYTES);
    localparam int unsigned RW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam int unsigned OW = $clog2(NUM_RES + 1);

    typedef logic [AW-1:0] addr_t;
    typedef logic [IW-1:0] id_t;
    typedef logic [RW-1:0] idx_t;

    localparam addr_t BEGIN_A = addr_t'(ADDR_BEGIN);
    localparam addr_t SPAN    = addr_t'(ADDR_END - ADDR_BEGIN);
    localparam idx_t  LAST    = idx_t'(NUM_RES - 1);

    // Single modular compare covers both bounds of the window.
    function automatic logic in_range(addr_t a);
        return addr_t'(a - BEGIN_A) <= SPAN;
    endfunction

    function automatic addr_t gran(addr_t a);
        return a >> GW;
    endfunction

    logic [NUM_RES-1:0] valid_q, valid_d;
    id_t                id_q   [NUM_RES];
    id_t                id_d   [NUM_RES];
    addr_t              gran_q [NUM_RES];
    addr_t              gran_d [NUM_RES];
    idx_t               rr_q, rr_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic               rsp_valid_q, rsp_ok_q;

    logic  sc_ready, sc_acc, sc_match, sc_ok;
    logic  lr_in, lr_hit, free;
    idx_t  lr_idx, free_idx, slot;
    addr_t lr_gran, sc_gran, wr_gran;

    assign sc_ready = !rsp_valid_q || bus.sc_rsp_ready_i;
    assign sc_acc   = bus.sc_valid_i && sc_ready;

    always_comb begin
        lr_in    = bus.lr_valid_i && in_range(bus.lr_addr_i);
        lr_gran  = gran(bus.lr_addr_i);
        sc_gran  = gran(bus.sc_addr_i);
        wr_gran  = gran(bus.wr_addr_i);
        sc_match = 1'b0;
        lr_hit   = 1'b0;
        lr_idx   = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            if (valid_q[i] && id_q[i] == bus.sc_id_i &&
                gran_q[i] == sc_gran)
                sc_match = 1'b1;
            if (valid_q[i] && id_q[i] == bus.lr_id_i) begin
                lr_hit = 1'b1;
                lr_idx = idx_t'(i);
            end
        end
        sc_ok = in_range(bus.sc_addr_i) && sc_match &&
                !(bus.wr_valid_i && wr_gran == sc_gran);

        valid_d = valid_q;
        id_d    = id_q;
        gran_d  = gran_q;
        rr_d    = rr_q;

        // Invalidations first, so an LR in the same cycle ends valid.
        for (int i = 0; i < NUM_RES; i++) begin
            if ((bus.wr_valid_i && gran_q[i] == wr_gran) ||
                (sc_acc && id_q[i] == bus.sc_id_i))
                valid_d[i] = 1'b0;
        end

        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_RES - 1; i >= 0; i--) begin
            if (!valid_d[i]) begin
                free     = 1'b1;
                free_idx = idx_t'(i);
            end
        end

        slot = rr_q;
        if (lr_hit)
            slot = lr_idx;
        else if (free)
            slot = free_idx;

        if (lr_in) begin
            valid_d[slot] = 1'b1;
            id_d[slot]    = bus.lr_id_i;
            gran_d[slot]  = lr_gran;
            if (!lr_hit && !free)
                rr_d = (rr_q == LAST) ? '0 : rr_q + idx_t'(1);
        end

        occ_d = '0;
        for (int i = 0; i < NUM_RES; i++)
            occ_d = occ_d + OW'(valid_d[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            rr_q        <= '0;
            occ_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            for (int i = 0; i < NUM_RES; i++) begin
                id_q[i]   <= '0;
                gran_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            gran_q  <= gran_d;
            rr_q    <= rr_d;
            occ_q   <= occ_d;
            if (sc_acc) begin
                rsp_valid_q <= 1'b1;
                rsp_ok_q    <= sc_ok;
            end else if (bus.sc_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.sc_ready_o     = sc_ready;
    assign bus.sc_rsp_valid_o = rsp_valid_q;
    assign bus.sc_rsp_ok_o    = rsp_ok_q;
    assign occupancy_o        = occ_q;
endmodule
